// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, FSM states and
// the helper that marks the iterative (multiply/divide) codes.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLL   = 4'd4;
  localparam logic [3:0] ALU_SLTU  = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_MUL   = 4'd8;
  localparam logic [3:0] ALU_MULHU = 4'd9;
  localparam logic [3:0] ALU_DIVU  = 4'd10;
  localparam logic [3:0] ALU_REMU  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [3:0] fn);
    return (fn >= ALU_MUL) && (fn <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle; `done` flags the final iteration and `result` is its post-step value.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [SH_W:0] CNT_INIT = (SH_W+1)'(WIDTH);
  localparam logic [SH_W:0] CNT_ONE  = (SH_W+1)'(1);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [SH_W:0]      r_cnt;
  logic               r_is_div;
  logic               r_sel_hi;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_rem;
  logic               w_ge;

  // Multiply: {hi,lo} starts as {0,b}; add a into hi when lo[0] is set, then
  // shift right. Divide: {rem,quo} starts as {0,a}; shift left, trial-subtract.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_shl     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge      = (w_shl >= {1'b0, r_opnd});
    w_rem     = w_ge ? WIDTH'(w_shl - {1'b0, r_opnd}) : w_shl[WIDTH-1:0];
    w_acc_nxt = r_is_div ? {w_rem, r_acc[WIDTH-2:0], w_ge}
                         : {w_sum, r_acc[WIDTH-1:1]};
  end

  assign done   = (r_cnt == CNT_ONE);
  assign result = r_sel_hi ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sel_hi <= 1'b0;
    end else if (start) begin
      r_acc    <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      r_opnd   <= is_div ? b : a;
      r_cnt    <= CNT_INIT;
      r_is_div <= is_div;
      r_sel_hi <= sel_hi;
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle ops answer one cycle after accept,
// multiply/divide after WIDTH+1; one op in flight, held in DONE until taken.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 4,
  parameter int SH_W   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  dataout,
  output logic              zero,
  output logic              sign
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_dataout;
  logic             r_zero;
  logic             r_sign;

  logic [3:0]       w_fn;
  logic             w_accept;
  logic             w_div_op;
  logic             w_div_zero;
  logic             w_start;
  logic             w_ltu;
  logic [WIDTH-1:0] w_single;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_res;

  assign w_fn       = func[3:0];
  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign w_accept   = in_valid && in_ready;
  assign w_div_op   = (w_fn == ALU_DIVU) || (w_fn == ALU_REMU);
  assign w_div_zero = w_div_op && (data2 == '0);
  assign w_start    = w_accept && is_iter(w_fn) && !w_div_zero;
  assign w_ltu      = (data1 < data2);

  // Divide-by-zero results are resolved here so they bypass the iterator.
  always_comb begin
    w_single = '0;
    case (w_fn)
      ALU_ADD:  w_single = data1 + data2;
      ALU_SUB:  w_single = data1 - data2;
      ALU_AND:  w_single = data1 & data2;
      ALU_OR:   w_single = data1 | data2;
      ALU_SLL:  w_single = data1 << data2[SH_W-1:0];
      ALU_SLTU: w_single = {{(WIDTH-1){1'b0}}, w_ltu};
      ALU_XOR:  w_single = data1 ^ data2;
      ALU_SRL:  w_single = data1 >> data2[SH_W-1:0];
      ALU_DIVU: w_single = '1;
      ALU_REMU: w_single = data1;
      default:  w_single = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .SH_W  (SH_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .is_div (w_div_op),
    .sel_hi ((w_fn == ALU_MULHU) || (w_fn == ALU_REMU)),
    .a      (data1),
    .b      (data2),
    .done   (w_iter_done),
    .result (w_iter_res)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_start ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_iter_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result flags live with dataout so all three stay stable through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dataout <= '0;
      r_zero    <= 1'b0;
      r_sign    <= 1'b0;
    end else if (w_accept) begin
      r_sign <= w_ltu;
      if (!w_start) begin
        r_dataout <= w_single;
        r_zero    <= (w_single == '0);
      end
    end else if ((r_state == ST_BUSY) && w_iter_done) begin
      r_dataout <= w_iter_res;
      r_zero    <= (w_iter_res == '0);
    end
  end

  assign dataout = r_dataout;
  assign zero    = r_zero;
  assign sign    = r_sign;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised plus directed bench for alu_mc against an arithmetic reference.
module tb_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data1;
  logic [W-1:0]  data2;
  logic [3:0]    func;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dataout;
  logic          zero;
  logic          sign;

  int n_checks = 0;
  int n_err    = 0;

  alu_mc #(.WIDTH(W), .FUNC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .zero      (zero),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input int f, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, p;
    ua = a;
    ub = b;
    p  = ua * ub;
    case (f)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a << (b % 32);
      5:  return (a < b) ? 32'd1 : 32'd0;
      6:  return a ^ b;
      7:  return a >> (b % 32);
      8:  return p[31:0];
      9:  return p[63:32];
      10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      11: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input int f, input logic [31:0] b);
    if (f == 8 || f == 9) return W + 1;
    if ((f == 10 || f == 11) && b != 0) return W + 1;
    return 1;
  endfunction

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_op(input string tag, input int f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    int guard;
    exp = ref_result(f, a, b);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    data1     = a;
    data2     = b;
    func      = 4'(f);
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    data1    = $urandom;
    data2    = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (lat == W / 2) chk({tag, ".busy_rdy"}, in_ready, 0);
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".latency"}, lat, ref_latency(f, b));
    chk({tag, ".dataout"}, dataout, exp);
    chk({tag, ".zero"}, zero, (exp == 0));
    chk({tag, ".sign"}, sign, (a < b));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_vld"}, out_valid, 1);
      chk({tag, ".hold_dat"}, dataout, exp);
      chk({tag, ".hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop_vld"}, out_valid, 0);
    chk({tag, ".back_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic seen;
    int   f;
    logic [31:0] a, b;

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    data1 = 32'd5; data2 = 32'd7; func = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.dataout", dataout, 0);
    chk("rst.zero", zero, 0);
    chk("rst.sign", sign, 0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.out_valid", out_valid, 0);

    run_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 5, 32'd3, 32'd5, 0);
    run_op("sll", 4, 32'd1, 32'h24, 0);
    run_op("srl", 7, 32'h8000_0000, 32'd31, 0);
    run_op("mul", 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu", 9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu", 10, 32'd100, 32'd7, 0);
    run_op("remu", 11, 32'd100, 32'd7, 0);
    run_op("divu0", 10, 32'hDEAD_BEEF, 32'd0, 0);
    run_op("remu0", 11, 32'h1234, 32'd0, 0);
    run_op("code13", 13, 32'h55, 32'h66, 0);
    run_op("hold5", 1, 32'd10, 32'd3, 5);

    // Reset during a multiply discards it.
    in_valid = 1'b1; data1 = 32'h1234_5678; data2 = 32'h9ABC_DEF0; func = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.dataout", dataout, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst.no_output", seen, 0);
    run_op("after_rst_add", 0, 32'd40, 32'd2, 0);

    for (int i = 0; i < 60; i++) begin
      f = $urandom_range(0, 15);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 50);
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised integer ALU for the RISC-V datapath.
- Supersets the single-cycle ALU function set with iterative RV32M-style multiply and divide.
- Single-cycle ops and iterative ops share one valid/ready handshake on input and output, so a multi-cycle pipeline can stall on it.
- Sits between operand select (ID/EX) and writeback; the stall unit monitors `in_ready`.

Parameters:
- `WIDTH`, 32, operand/result width; power of two, ≥8.
- `FUNC_W`, 4, width of function code.
- `SH_W`, $clog2(WIDTH), derived: shift-amount bits taken from `data2`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands and func valid
- `in_ready`  out  1  block can accept an operation
- `data1`  in  WIDTH  operand A
- `data2`  in  WIDTH  operand B
- `func`  in  FUNC_W  operation select
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result
- `dataout`  out  WIDTH  result
- `zero`  out  1  `dataout == 0`
- `sign`  out  1  `data1 < data2`, unsigned, for the accepted operands

Behaviour:
- Func codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SLTU (result 1/0), 6 XOR, 7 SRL
  - 8 MUL (low WIDTH of product), 9 MULHU (high WIDTH, unsigned), 10 DIVU, 11 REMU
  - 12–15 → result 0, single-cycle
- Shifts use `data2[SH_W-1:0]` only. All arithmetic is unsigned and wraps modulo 2^WIDTH.
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- `in_ready = (state == IDLE)`.
- Accept occurs on a clock edge with `in_valid && in_ready`. Operands, func and `sign` are captured on that edge.
- Single-cycle ops (0–7, 12–15) and DIVU/REMU with `data2 == 0`:
  - Result registered on the accept edge; state → DONE.
  - `out_valid = 1` the next cycle (latency 1).
- MUL/MULHU: shift-add over a 2·WIDTH accumulator.
  - IDLE → BUSY for exactly WIDTH cycles, then → DONE.
  - `out_valid` asserts WIDTH+1 cycles after accept.
- DIVU/REMU with `data2 != 0`: restoring division, one quotient bit per cycle, WIDTH cycles in BUSY, same latency as MUL.
- Divide by zero (RISC-V semantics): DIVU = all ones; REMU = `data1`.
- Iteration counter is SH_W+1 bits. It loads WIDTH on accept and decrements in BUSY. BUSY → DONE when the counter reaches 1.
- DONE:
  - `dataout`, `zero` and `sign` are held stable while `out_valid` is high.
  - On `out_ready`, state → IDLE and `out_valid` drops the next cycle.
  - No new accept in the same cycle; back-to-back throughput is one op per 2 cycles for single-cycle ops.
- `in_valid` during BUSY/DONE is ignored; the source must hold it.
- Reset (any state, including mid-iteration): next cycle state = IDLE, `out_valid = 0`, `dataout = 0`, `zero = 0`, `sign = 0`, counter = 0. The in-flight operation is discarded with no output.
- `zero` and `sign` are registered alongside `dataout`; no combinational path from inputs to outputs except `in_ready` from the state.

Decomposition:
- Package `alu_pkg`: func-code localparams (`ALU_ADD`…`ALU_REMU`), FSM state enum, the `is_iter(func)` helper.
- Sub-module `alu_muldiv_iter`: holds the accumulator, counter, and shift-add / restoring-divide datapath, with `start` and `done` strobes.
- The top level holds the FSM, single-cycle mux, handshake, and output registers.

Test Plan:
- Reset with `in_valid = 1` held → `in_ready = 1` and `out_valid = 0` the cycle after `rst` falls; `dataout = 0`.
- ADD `0xFFFFFFFF + 1`, `out_ready = 1` → `out_valid` one cycle after accept; `dataout = 0`, `zero = 1`, `sign = 0`. Then SLTU `3, 5` → `dataout = 1`, `sign = 1`.
- SLL `data1 = 1`, `data2 = 0x00000024` → shift by 4, `dataout = 0x10`. SRL `0x80000000 >> 31` → `0x1`.
- MUL `0xFFFFFFFF × 0xFFFFFFFF` → `out_valid` exactly 33 cycles after accept, `dataout = 0x00000001`. MULHU, same operands → `0xFFFFFFFE`. `in_ready = 0` throughout BUSY.
- DIVU `100 / 7` → `14`; REMU → `2`, latency 33. DIVU `x / 0` → `0xFFFFFFFF` at latency 1; REMU `0x1234 / 0` → `0x1234`.
- `out_ready` held low 5 cycles in DONE → `dataout` stable, `in_ready = 0`. Assert `rst` 10 cycles into a MUL → IDLE, `out_valid` never asserts for that op, next ADD correct.
